axi_slave_ram: RTL and testbench

- AXI3-style burst responder backed by an internal word-wide RAM.
- It is the slave end of the cache-side AXI master. It accepts the master's AR/R/AW/W/B traffic and serves it from local storage.
- Used as the bench/simulation memory for the cache and bus interface, and as an on-chip scratch RAM.
- Read and write channels run as independent state machines sharing one memory array.

---
 rtl/axi_slave_ram_if.sv | 70 +++++++
 rtl/axi_slave_ram.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_if.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_if
//   AXI3-style bus bundle between the cache-side master and axi_slave_ram.
//   Channels: AR (read address), R (read data), AW (write address),
//             W (write data), B (write response).
//   Modports:
//     slave  - memory side: drives the ready signals on AR/AW/W and all R/B
//              outputs; receives everything else.
//     master - requester side, the mirror image of slave.
// ---------------------------------------------------------------------------
interface axi_slave_ram_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram
//   AXI3-style burst responder backed by a 2^ADDR_W x 32-bit RAM. Serves as
//   simulation memory for the cache/bus interface and as on-chip scratch RAM.
//   Read and write sides are independent state machines sharing the array;
//   each channel sustains one beat per cycle.
//
//   Parameters:
//     ADDR_W     - word-address width (default 10 -> 4 KB)
//     READ_DELAY - idle cycles between AR handshake and first R beat (0..15)
//
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - axi_slave_ram_if.slave (AR/R/AW/W/B channels)
//
//   Addressing: word index = addr[ADDR_W+1:2]; upper bits alias. Transfers
//   are always 4 bytes. Bursts: FIXED, INCR, WRAP (len 1/3/7/15); 2'b11 acts
//   as INCR.
// ---------------------------------------------------------------------------
module axi_slave_ram #(
  parameter int ADDR_W     = 10,
  parameter int READ_DELAY = 0
) (
  input  logic            clk,
  input  logic            rst,
  axi_slave_ram_if.slave  bus
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Word address of the beat following 'addr'. WRAP keeps the bits above the
  // (len+1)-word window and lets the low bits roll over; len is 1/3/7/15 so
  // it doubles as the window mask.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [7:0]        len,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask = ADDR_W'(len);
    inc  = addr + ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // Only the upper/lower address bits that select nothing; kept so the
  // aliasing is explicit rather than an accident of truncation.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.araddr[31:ADDR_W+2], bus.araddr[1:0],
                              bus.awaddr[31:ADDR_W+2], bus.awaddr[1:0]};

  // -------------------------------------------------------------------------
  // Read side
  // -------------------------------------------------------------------------
  r_state_t          r_state, r_next;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_nxt;
  logic [7:0]        r_len;
  logic [1:0]        r_burst;
  logic [7:0]        r_cnt;
  logic [3:0]        r_delay;
  logic [31:0]       rdata_q;
  logic              r_last_beat;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign r_last_beat = (r_cnt == r_len);
  assign r_addr_nxt  = next_addr(r_addr, r_len, r_burst);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    r_next      = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = r_addr_nxt;
    case (r_state)
      R_IDLE: begin
        bus.arready = 1'b1;
        rd_addr     = bus.araddr[ADDR_W+1:2];
        if (bus.arvalid) begin
          r_next = (READ_DELAY == 0) ? R_DATA : R_WAIT;
          rd_en  = (READ_DELAY == 0);
        end
      end
      R_WAIT: begin
        rd_addr = r_addr;
        if (r_delay == 4'd0) begin
          r_next = R_DATA;
          rd_en  = 1'b1;
        end
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = r_last_beat;
        if (bus.rready) begin
          // Prefetch the next beat; on the last beat the burst just ends.
          rd_en = !r_last_beat;
          if (r_last_beat) r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_delay <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (bus.arvalid) begin
          r_id    <= bus.arid;
          r_addr  <= bus.araddr[ADDR_W+1:2];
          r_len   <= bus.arlen;
          r_burst <= bus.arburst;
          r_cnt   <= '0;
          r_delay <= 4'(READ_DELAY - 1);
        end
        R_WAIT: if (r_delay != 4'd0) r_delay <= r_delay - 4'd1;
        R_DATA: if (bus.rready) begin
          r_addr <= r_addr_nxt;
          r_cnt  <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // rdata only changes on a load, so it holds through R stalls. A same-cycle
  // write to the loaded word is not forwarded: the old contents are taken.
  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_addr];
  end

  assign bus.rid   = r_id;
  assign bus.rdata = rdata_q;
  assign bus.rresp = RESP_OKAY;

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  w_state_t          w_state, w_next;
  logic [3:0]        w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [1:0]        w_burst;
  logic [7:0]        w_cnt;
  logic [1:0]        w_resp;
  logic              w_fire;
  logic              w_end;

  assign w_fire = (w_state == W_DATA) && bus.wvalid;
  // The data phase closes on whichever comes first: wlast or the beat count.
  assign w_end  = w_fire && (bus.wlast || (w_cnt == w_len));

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next      = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (w_end) w_next = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_resp  <= RESP_OKAY;
    end else begin
      if (w_state == W_IDLE && bus.awvalid) begin
        w_id    <= bus.awid;
        w_addr  <= bus.awaddr[ADDR_W+1:2];
        w_len   <= bus.awlen;
        w_burst <= bus.awburst;
        w_cnt   <= '0;
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 8'd1;
      end
      // A clean burst has wlast exactly on the len-th beat; anything else
      // (early wlast or missing wlast) is reported as SLVERR.
      if (w_end)
        w_resp <= (bus.wlast && (w_cnt == w_len)) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // NOTE: the array has no reset; clearing every word would forbid mapping it
  // onto a RAM macro, and contents are defined only after software writes.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem[w_addr][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
  end

  assign bus.bid   = w_id;
  assign bus.bresp = w_resp;

endmodule

// File: tb/tb_axi_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_ram
//   Self-checking bench for axi_slave_ram. The main instance (READ_DELAY=0)
//   is driven with directed and randomized bursts and compared against a
//   word-array reference model that computes beat addresses arithmetically.
//   A second instance (READ_DELAY=2) covers read latency and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_axi_slave_ram;

  typedef logic [31:0] word_arr_t [16];
  typedef logic [3:0]  strb_arr_t [16];

  logic clk;
  logic rst;
  logic rst2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [1024];

  axi_slave_ram_if bus ();
  axi_slave_ram_if bus2 ();

  axi_slave_ram #(.ADDR_W(10), .READ_DELAY(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  axi_slave_ram #(.ADDR_W(10), .READ_DELAY(2)) dut_dly (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte address of beat i of a burst, straight from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input logic [1:0] burst, input int i);
    int unsigned size;
    logic [31:0] base;
    case (burst)
      2'b00: return start;
      2'b10: begin
        size = 32'(len + 1) * 4;
        base = start - (start % size);
        return base + ((start - base) + 32'(4 * i)) % size;
      end
      default: return start + 32'(4 * i);
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % 1024);
  endfunction

  // wlast_at: beat index carrying wlast (> len means wlast never asserted).
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [3:0] id, input word_arr_t data, input strb_arr_t strb,
                           input int wlast_at, input bit gaps);
    int n_beats;
    int t;
    int idx;
    logic [1:0] exp_resp;
    n_beats  = (wlast_at <= len) ? wlast_at + 1 : len + 1;
    exp_resp = (wlast_at == len) ? 2'b00 : 2'b10;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awburst = burst;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 100) begin @(negedge clk); t++; end
    check("awready", 32'(bus.awready), 32'd1);
    if (!bus.awready) begin bus.awvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.wdata  = data[i];
      bus.wstrb  = strb[i];
      bus.wlast  = (i == wlast_at);
      bus.wvalid = 1'b1;
      @(negedge clk);
      t = 0;
      while (!bus.wready && t < 100) begin @(negedge clk); t++; end
      check("wready", 32'(bus.wready), 32'd1);
      if (!bus.wready) begin bus.wvalid = 1'b0; return; end
      @(posedge clk); #1;
      idx = word_of(beat_addr(addr, len, burst, i));
      for (int b = 0; b < 4; b++)
        if (strb[i][b]) model[idx][8*b +: 8] = data[i][8*b +: 8];
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    @(negedge clk);
    check("bvalid_next_cycle", 32'(bus.bvalid), 32'd1);
    check("bid", 32'(bus.bid), 32'(id));
    check("bresp", 32'(bus.bresp), 32'(exp_resp));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bvalid_hold", 32'(bus.bvalid), 32'd1);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", 32'(bus.bvalid), 32'd0);
    check("awready_after_b", 32'(bus.awready), 32'd1);
  endtask

  // stall_mode: 0 = rready always high, 1 = 1,0,1,0..., 2 = random stalls.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id, input int stall_mode);
    int t;
    int stall;
    logic [31:0] exp;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arburst = burst;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 100) begin @(negedge clk); t++; end
    check("arready", 32'(bus.arready), 32'd1);
    if (!bus.arready) begin bus.arvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      stall = (stall_mode == 1) ? ((i > 0) ? 1 : 0) :
              (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      exp = model[word_of(beat_addr(addr, len, burst, i))];
      bus.rready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("rvalid_stall", 32'(bus.rvalid), 32'd1);
        check("rdata_hold", bus.rdata, exp);
        @(posedge clk); #1;
      end
      bus.rready = 1'b1;
      @(negedge clk);
      check("rvalid", 32'(bus.rvalid), 32'd1);
      check("rdata", bus.rdata, exp);
      check("rid", 32'(bus.rid), 32'(id));
      check("rlast", 32'(bus.rlast), (i == len) ? 32'd1 : 32'd0);
      check("rresp", 32'(bus.rresp), 32'd0);
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    @(negedge clk);
    check("rvalid_end", 32'(bus.rvalid), 32'd0);
    check("arready_end", 32'(bus.arready), 32'd1);
  endtask

  task automatic idle_inputs();
    bus.arid = '0;  bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awid = '0;  bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0;  bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus2.arid = '0;  bus2.araddr = '0; bus2.arlen = '0; bus2.arburst = '0; bus2.arvalid = 1'b0;
    bus2.rready = 1'b0;
    bus2.awid = '0;  bus2.awaddr = '0; bus2.awlen = '0; bus2.awburst = '0; bus2.awvalid = 1'b0;
    bus2.wdata = '0; bus2.wstrb = '0;  bus2.wlast = 1'b0; bus2.wvalid = 1'b0;
    bus2.bready = 1'b0;
  endtask

  initial begin
    word_arr_t   d;
    strb_arr_t   s;
    logic [1:0]  burst;
    int          len;
    int          wl;
    int          ws;
    int          rs;
    logic [31:0] hi;
    logic [31:0] wa;
    logic [31:0] ra;

    idle_inputs();
    rst  = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rlast",   32'(bus.rlast),   32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_rid",     32'(bus.rid),     32'd0);
    check("rst_bid",     32'(bus.bid),     32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);

    // Fill the whole array so every later read has a known expectation.
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) begin d[i] = $urandom(); s[i] = 4'hF; end
      axi_write(32'(k * 64), 15, 2'b01, 4'(k), d, s, 15, 1'b0);
    end

    // Single-beat write then read
    d[0] = 32'hDEADBEEF; s[0] = 4'hF;
    axi_write(32'h10, 0, 2'b01, 4'd3, d, s, 0, 1'b0);
    axi_read(32'h10, 0, 2'b01, 4'd5, 0);

    // INCR 4-beat, read back with rready toggling
    for (int i = 0; i < 4; i++) begin d[i] = 32'(i + 1); s[i] = 4'hF; end
    axi_write(32'h100, 3, 2'b01, 4'd1, d, s, 3, 1'b0);
    axi_read(32'h100, 3, 2'b01, 4'd2, 1);

    // WRAP read len 3 starting mid-window
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC; d[3] = 32'hD;
    axi_write(32'h10, 3, 2'b01, 4'd4, d, s, 3, 1'b0);
    axi_read(32'h18, 3, 2'b10, 4'd6, 0);

    // Byte strobes
    d[0] = 32'h11223344; s[0] = 4'hF;
    axi_write(32'h20, 0, 2'b01, 4'd7, d, s, 0, 1'b0);
    d[0] = 32'hAABBCCDD; s[0] = 4'b0101;
    axi_write(32'h20, 0, 2'b01, 4'd8, d, s, 0, 1'b0);
    axi_read(32'h20, 0, 2'b01, 4'd9, 0);

    // Early wlast: only two beats land, SLVERR reported
    for (int i = 0; i < 4; i++) begin d[i] = 32'h5000 + 32'(i); s[i] = 4'hF; end
    axi_write(32'h200, 3, 2'b01, 4'd10, d, s, 3, 1'b0);
    for (int i = 0; i < 4; i++) d[i] = 32'h9000 + 32'(i);
    axi_write(32'h200, 3, 2'b01, 4'd11, d, s, 1, 1'b0);
    axi_read(32'h200, 3, 2'b01, 4'd12, 0);

    // Randomized bursts; a third of them run AR and AW concurrently on
    // disjoint halves of the array.
    for (int it = 0; it < 40; it++) begin
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'b10) ? (1 << $urandom_range(1, 4)) - 1 : int'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       wl = int'($urandom_range(0, len));
        1:       wl = 99;
        default: wl = len;
      endcase
      for (int i = 0; i < 16; i++) begin
        d[i] = $urandom();
        s[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end
      hi = $urandom();
      if ($urandom_range(0, 2) == 0) begin
        ws = 512 + int'($urandom_range(0, 480));
        rs = int'($urandom_range(0, 480));
        wa = {hi[31:12], 10'(ws), 2'b00};
        ra = {hi[19:0], 10'(rs), 2'b00};
        fork
          axi_write(wa, len, burst, 4'(it), d, s, wl, 1'b1);
          axi_read(ra, len, burst, 4'(it + 1), 2);
        join
      end else begin
        ws = int'($urandom_range(0, 1023));
        wa = {hi[31:12], 10'(ws), 2'b00};
        axi_write(wa, len, burst, 4'(it), d, s, wl, 1'($urandom_range(0, 1)));
        axi_read(wa, len, burst, 4'(it + 3), int'($urandom_range(0, 2)));
      end
    end

    // READ_DELAY=2 instance: latency and mid-burst reset
    @(negedge clk);
    bus2.arid    = 4'h7;
    bus2.araddr  = 32'h0;
    bus2.arlen   = 8'd3;
    bus2.arburst = 2'b01;
    bus2.arvalid = 1'b1;
    check("d2_arready", 32'(bus2.arready), 32'd1);
    @(posedge clk); #1;
    bus2.arvalid = 1'b0;
    @(negedge clk);
    check("d2_rvalid_t1", 32'(bus2.rvalid), 32'd0);
    @(negedge clk);
    check("d2_rvalid_t2", 32'(bus2.rvalid), 32'd0);
    @(negedge clk);
    check("d2_rvalid_t3", 32'(bus2.rvalid), 32'd1);
    check("d2_rid", 32'(bus2.rid), 32'd7);
    check("d2_arready_busy", 32'(bus2.arready), 32'd0);
    bus2.awid    = 4'h2;
    bus2.awaddr  = 32'h40;
    bus2.awlen   = 8'd0;
    bus2.awburst = 2'b01;
    bus2.awvalid = 1'b1;
    @(posedge clk); #1;
    bus2.awvalid = 1'b0;
    bus2.wdata   = 32'h12345678;
    bus2.wstrb   = 4'hF;
    bus2.wlast   = 1'b1;
    bus2.wvalid  = 1'b1;
    @(negedge clk);
    check("d2_wready", 32'(bus2.wready), 32'd1);
    @(posedge clk); #1;
    bus2.wvalid = 1'b0;
    bus2.wlast  = 1'b0;
    @(negedge clk);
    check("d2_bvalid", 32'(bus2.bvalid), 32'd1);
    check("d2_rvalid_stalled", 32'(bus2.rvalid), 32'd1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    check("d2_rst_rvalid",  32'(bus2.rvalid),  32'd0);
    check("d2_rst_rlast",   32'(bus2.rlast),   32'd0);
    check("d2_rst_arready", 32'(bus2.arready), 32'd1);
    check("d2_rst_awready", 32'(bus2.awready), 32'd1);
    check("d2_rst_bvalid",  32'(bus2.bvalid),  32'd0);
    check("d2_rst_wready",  32'(bus2.wready),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
